// File: rtl/mult_result_collector.sv
// mult_result_collector
// Follows each frame of the 8x8 sequential shift-add multiplier from operand
// sampling to product valid. Captures the product together with a user tag
// into a small first-word-fall-through FIFO, and presents the results on a
// valid/ready stream. Sticky flags report dropped captures (FIFO full) and
// frames that restart while a previous frame is still pending.

module mult_result_collector #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
    parameter int LATENCY = 9,   // frame_start to product valid, 2..15
    parameter int TAGW    = 4    // tag width
) (
    input  logic                     clk,
    input  logic                     rst,          // async, active-low
    input  logic                     frame_start,
    input  logic [TAGW-1:0]          frame_tag,
    input  logic [15:0]              prod,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic [TAGW-1:0]          res_tag,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_flags
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [3:0]      LAT     = 4'(LATENCY);
    localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    // One FIFO entry: the tag travels alongside the unmodified product.
    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [15:0]     data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]       r_cnt;        // frame countdown, 0 = idle
    logic [TAGW-1:0]  r_tag;        // tag of the pending frame
    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;      // occupancy, 0..DEPTH
    logic             r_overflow;
    logic             r_frame_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic   w_capture;      // product is on prod this cycle
    logic   w_empty;
    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic   w_drop;         // capture lost because the FIFO stays full
    logic   w_restart;      // frame_start while a frame is pending
    entry_t w_head;
    entry_t w_new;

    assign w_capture = (r_cnt == 4'd1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL);
    // Pop only when something is held; ready on an empty FIFO is ignored.
    assign w_pop     = !w_empty && res_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;
    assign w_restart = frame_start && (r_cnt != 4'd0);
    assign w_new     = '{tag: r_tag, data: prod};
    assign w_head    = r_mem[r_rptr];

    // ------------------------------------------------------------------
    // Frame tracker: load on frame_start, count down, release after capture.
    // A restart while cnt>1 simply reloads, abandoning the pending frame;
    // a restart at cnt==1 still captures because w_capture uses the old count.
    // ------------------------------------------------------------------
    // Track the in-flight frame and latch its tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
            r_tag <= '0;
        end else if (frame_start) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block sees the pre-edge values of the others
            // (the capture below relies on r_tag still holding the old frame).
            r_cnt <= LAT;
            r_tag <= frame_tag;
        end else if (r_cnt > 4'd1) begin
            r_cnt <= r_cnt - 4'd1;
        end else if (w_capture) begin
            r_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // Write the captured entry at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // after it has been written, because reads are gated by r_count.
        if (w_push) begin
            r_mem[r_wptr] <= w_new;
        end
    end

    // Advance the pointers and occupancy on push/pop; reset discards contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a new set event wins over a clear in the same cycle.
    // ------------------------------------------------------------------
    // Hold overflow/frame_err until explicitly cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end

            if (w_restart) begin
                r_frame_err <= 1'b1;
            end else if (clr_flags) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, so res_valid has no path
    // from res_ready. Head fields read as zero while the FIFO is empty.
    // ------------------------------------------------------------------
    assign res_valid = !w_empty;
    assign res_data  = w_empty ? 16'd0 : w_head.data;
    assign res_tag   = w_empty ? '0    : w_head.tag;
    assign fill      = r_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mult_result_collector.sv
// Self-checking bench for mult_result_collector. Expected FIFO results are
// pushed to a scoreboard queue as frames are driven and compared in order as
// the DUT presents them on the result stream.

module tb_mult_result_collector;

    localparam int DEPTH   = 4;
    localparam int LATENCY = 9;
    localparam int TAGW    = 4;

    logic                   clk;
    logic                   rst;
    logic                   frame_start;
    logic [TAGW-1:0]        frame_tag;
    logic [15:0]            prod;
    logic                   res_valid;
    logic                   res_ready;
    logic [15:0]            res_data;
    logic [TAGW-1:0]        res_tag;
    logic [$clog2(DEPTH):0] fill;
    logic                   overflow;
    logic                   frame_err;
    logic                   clr_flags;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [15:0]     data;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_result_collector #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .TAGW    (TAGW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_tag   (frame_tag),
        .prod        (prod),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .fill        (fill),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .clr_flags   (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Drive one frame: start now, product valid LATENCY cycles later. The
    // other cycles carry random prod so a mistimed sample is visible.
    task automatic run_frame(input logic [TAGW-1:0] tag, input logic [15:0] p,
                             input logic rdy_cap, input logic clr_cap);
        frame_start = 1'b1;
        frame_tag   = tag;
        prod        = 16'($urandom);
        step();
        frame_start = 1'b0;
        frame_tag   = TAGW'($urandom);
        for (int i = 0; i < LATENCY - 1; i++) begin
            prod = 16'($urandom);
            step();
        end
        prod      = p;
        res_ready = rdy_cap;
        clr_flags = clr_cap;
        step();
        prod      = 16'($urandom);
        res_ready = 1'b0;
        clr_flags = 1'b0;
    endtask

    // Scoreboard consumer: drain the FIFO and compare each head in order.
    task automatic sb_drain(input string name, input int budget);
        int cyc = 0;
        res_ready = 1'b1;
        while (sb.size() != 0 && cyc < budget) begin
            if (res_valid) begin
                n_checks++;
                if (res_data !== sb[0].data || res_tag !== sb[0].tag) begin
                    n_fail++;
                    $display("FAIL %s_pop: got data=%h tag=%0d, expected data=%h tag=%0d",
                             name, res_data, res_tag, sb[0].data, sb[0].tag);
                end
                void'(sb.pop_front());
            end
            step();
            cyc++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d results still expected, expected 0", name, sb.size());
            sb.delete();
        end
        n_checks++;
        if (res_valid !== 1'b0 || fill !== '0) begin
            n_fail++;
            $display("FAIL %s_empty: got valid=%b fill=%0d, expected valid=0 fill=0",
                     name, res_valid, fill);
        end
        res_ready = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        frame_start = 1'b0;
        frame_tag = '0;
        prod = '0;
        res_ready = 1'b0;
        clr_flags = 1'b0;
        wait_cycles(3);
        n_checks++;
        if ({res_valid, res_data, res_tag, fill, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h tag=%0d fill=%0d ovf=%b ferr=%b, expected all 0",
                     res_valid, res_data, res_tag, fill, overflow, frame_err);
        end
        rst = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        frame_start = 1'b1;
        frame_tag = 4'd3;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            prod = 16'($urandom);
            step();
        end
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_bypass: got valid=%b, expected 0", res_valid);
        end
        prod = 16'hFE01;
        sb.push_back('{tag: 4'd3, data: 16'hFE01});
        step();
        prod = 16'($urandom);
        n_checks++;
        if (res_valid !== 1'b1 || fill !== 3'd1 || res_data !== sb[0].data || res_tag !== sb[0].tag) begin
            n_fail++;
            $display("FAIL single_head: got valid=%b fill=%0d data=%h tag=%0d, expected valid=1 fill=1 data=%h tag=%0d",
                     res_valid, fill, res_data, res_tag, sb[0].data, sb[0].tag);
        end
        void'(sb.pop_front());
        step();
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, res_data, res_tag, fill, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL single_after_pop: got valid=%b data=%h tag=%0d fill=%0d ovf=%b ferr=%b, expected all 0",
                     res_valid, res_data, res_tag, fill, overflow, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            run_frame(TAGW'(i), 16'(i), 1'b0, 1'b0);
            if (i <= DEPTH) sb.push_back('{tag: TAGW'(i), data: 16'(i)});
        end
        n_checks++;
        if (fill !== 3'd4 || overflow !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got fill=%0d ovf=%b ferr=%b, expected fill=4 ovf=1 ferr=0",
                     fill, overflow, frame_err);
        end
        sb_drain("b2b", 20);
        clear_flags();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_clr: got ovf=%b, expected 0", overflow);
        end
    endtask

    task automatic test_frame_err();
        frame_start = 1'b1;
        frame_tag = 4'd6;
        step();
        frame_start = 1'b0;
        prod = 16'($urandom);
        wait_cycles(3);
        frame_start = 1'b1;
        frame_tag = 4'd7;
        step();
        frame_start = 1'b0;
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_set: got ferr=%b, expected 1", frame_err);
        end
        wait_cycles(4);
        prod = 16'h1111;
        step();
        prod = 16'($urandom);
        n_checks++;
        if (res_valid !== 1'b0 || fill !== '0) begin
            n_fail++;
            $display("FAIL ferr_abandoned: got valid=%b fill=%0d, expected valid=0 fill=0", res_valid, fill);
        end
        wait_cycles(3);
        prod = 16'h2222;
        sb.push_back('{tag: 4'd7, data: 16'h2222});
        step();
        prod = 16'($urandom);
        n_checks++;
        if (fill !== 3'd1 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_capture: got fill=%0d ferr=%b, expected fill=1 ferr=1", fill, frame_err);
        end
        sb_drain("ferr", 10);
        clear_flags();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clr: got ferr=%b, expected 0", frame_err);
        end
    endtask

    // Restart exactly at cnt==1: old frame still captured, new frame proceeds.
    task automatic test_err_at_capture();
        frame_start = 1'b1;
        frame_tag = 4'd2;
        step();
        frame_start = 1'b0;
        prod = 16'($urandom);
        wait_cycles(LATENCY - 1);
        frame_start = 1'b1;
        frame_tag = 4'd4;
        prod = 16'h3333;
        sb.push_back('{tag: 4'd2, data: 16'h3333});
        step();
        frame_start = 1'b0;
        prod = 16'($urandom);
        n_checks++;
        if (frame_err !== 1'b1 || fill !== 3'd1) begin
            n_fail++;
            $display("FAIL cap_restart: got ferr=%b fill=%0d, expected ferr=1 fill=1", frame_err, fill);
        end
        wait_cycles(LATENCY - 1);
        prod = 16'h4444;
        sb.push_back('{tag: 4'd4, data: 16'h4444});
        step();
        prod = 16'($urandom);
        sb_drain("cap_restart", 10);
        clear_flags();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) begin
            run_frame(TAGW'(8 + i), 16'(16'h10 + i), 1'b0, 1'b0);
            sb.push_back('{tag: TAGW'(8 + i), data: 16'(16'h10 + i)});
        end
        n_checks++;
        if (fill !== 3'd4 || res_data !== sb[0].data || res_tag !== sb[0].tag) begin
            n_fail++;
            $display("FAIL fullpop_pre: got fill=%0d data=%h tag=%0d, expected fill=4 data=%h tag=%0d",
                     fill, res_data, res_tag, sb[0].data, sb[0].tag);
        end
        void'(sb.pop_front());
        sb.push_back('{tag: 4'd12, data: 16'h0014});
        run_frame(4'd12, 16'h0014, 1'b1, 1'b0);
        n_checks++;
        if (fill !== 3'd4 || overflow !== 1'b0 || res_data !== sb[0].data || res_tag !== sb[0].tag) begin
            n_fail++;
            $display("FAIL fullpop_post: got fill=%0d ovf=%b data=%h tag=%0d, expected fill=4 ovf=0 data=%h tag=%0d",
                     fill, overflow, res_data, res_tag, sb[0].data, sb[0].tag);
        end
        sb_drain("fullpop", 20);
    endtask

    task automatic test_overflow_clr();
        for (int i = 0; i < DEPTH; i++) begin
            run_frame(TAGW'(i), 16'(16'hA000 + i), 1'b0, 1'b0);
            sb.push_back('{tag: TAGW'(i), data: 16'(16'hA000 + i)});
        end
        run_frame(4'd15, 16'hBBBB, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b1 || fill !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%b fill=%0d, expected ovf=1 fill=4", overflow, fill);
        end
        clear_flags();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got ovf=%b, expected 0", overflow);
        end
        sb_drain("ovf", 20);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            run_frame(TAGW'(5 + i), 16'(16'hC000 + i), 1'b0, 1'b0);
            sb.push_back('{tag: TAGW'(5 + i), data: 16'(16'hC000 + i)});
        end
        frame_start = 1'b1;
        frame_tag = 4'd9;
        step();
        frame_start = 1'b0;
        wait_cycles(4);
        rst = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if (res_valid !== 1'b0 || fill !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got valid=%b fill=%0d, expected valid=0 fill=0", res_valid, fill);
        end
        step();
        rst = 1'b1;
        prod = 16'($urandom);
        wait_cycles(3);
        prod = 16'hBEEF;
        step();
        prod = 16'($urandom);
        wait_cycles(2);
        n_checks++;
        if ({res_valid, fill, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_no_capture: got valid=%b fill=%0d ovf=%b ferr=%b, expected all 0",
                     res_valid, fill, overflow, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_err_at_capture();
        test_full_pop();
        test_overflow_clr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_result_collector.md
# mult_result_collector

Downstream companion to the 8x8 sequential shift-add multiplier. It tracks each multiplier frame from the cycle operands are sampled (stage 0) to the cycle the full product is on the multiplier output (stage 9). It captures that product with a user tag into a small FIFO and presents results on a valid/ready stream. Sticky flags report FIFO overflow and frame-protocol errors.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, >= 2.
- `LATENCY`, 9: cycles from `frame_start` to product valid on `prod`; range 2..15.
- `TAGW`, 4: tag width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears all state immediately.
- `frame_start`  in  1  high in the cycle the multiplier is in stage 0, i.e. samples `in1`/`in2` at the closing edge.
- `frame_tag`  in  TAGW  tag for the frame; sampled with `frame_start`.
- `prod`  in  16  multiplier `out`.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  consumer accepts head.
- `res_data`  out  16  head product; 0 when empty.
- `res_tag`  out  TAGW  head tag; 0 when empty.
- `fill`  out  $clog2(DEPTH)+1  entries held.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; `frame_start` arrived while a frame was pending.
- `clr_flags`  in  1  synchronous clear of `overflow` and `frame_err`.

## Operation
- Frame tracker: 4-bit down-counter `cnt` plus a tag register. `cnt==0` means idle.
  - `frame_start` sampled: `cnt <= LATENCY` and the tag is latched.
  - Otherwise, while `cnt>1`: `cnt <= cnt-1`.
  - `cnt==1`: capture event pushes `{tag, prod}` and sets `cnt <= 0`, unless reloaded in the same cycle.
- `frame_start` with `cnt!=0` sets `frame_err`:
  - `cnt==1`: the capture still occurs, then the new frame loads.
  - `cnt>1`: the pending frame is abandoned with no capture, and the new frame loads.
- FIFO: circular buffer with read/write pointers and an occupancy count; first-word-fall-through.
  - `res_data`/`res_tag` are driven from the head entry.
  - Pop when `res_valid && res_ready`.
- Full with capture and no pop: capture dropped, `overflow <= 1`, contents unchanged.
- Full with capture and pop in the same cycle: both occur, `fill` stays `DEPTH`, no overflow.
- Empty with capture: the entry appears next cycle; no same-cycle bypass.
- `res_ready` while empty: ignored.
- Flags: set has priority over `clr_flags` in the same cycle.
- Products are 16-bit unsigned and stored unmodified; max 65025 (0xFE01).
- Reset mid-frame: pending frame and FIFO contents discarded. A later `prod` for that frame is never captured.

## Timing
- Reset values: `res_valid=0`, `res_data=0`, `res_tag=0`, `fill=0`, `overflow=0`, `frame_err=0`, `cnt=0`.
- `frame_start` in cycle k: `prod` is sampled at the edge closing cycle k+LATENCY. `res_valid=1` from cycle k+LATENCY+1.
- The back-to-back multiplier period is 10 cycles. `cnt` is 0 at the next `frame_start`, so a frame every LATENCY+1 cycles is legal with no error.
- `res_valid` depends only on registered state; no combinational path from `res_ready` to `res_valid`.
- `fill` updates the cycle after a push or pop and reflects the net change.
- `frame_err`/`overflow` rise the cycle after the causing edge and hold until `clr_flags` or reset.

## Test plan
- Single frame: `frame_start=1`, tag 3 at cycle 5; `prod=0xFE01` during cycle 14; `res_ready=1` -> `res_valid` high cycle 15 with data 0xFE01, tag 3; popped; `fill` 1 then 0; no flags.
- Back-to-back: 5 frames every 10 cycles, tags 1..5, products 1..5, `res_ready=0` -> `fill=4`, `overflow=1` after the 5th capture; raising ready drains 1,2,3,4 in order; product 5 is absent.
- Protocol error: second `frame_start` (tag 7) 4 cycles after the first -> `frame_err=1`; no capture at first+9; one capture, tag 7, at second+9.
- Full FIFO with capture and pop in the same cycle -> `fill` stays 4, `overflow` stays 0, head advances, new entry at tail.
- `rst` low while `cnt=5` with 2 entries queued -> `res_valid=0`, `fill=0` immediately; no capture when the old frame's `prod` arrives.
- `clr_flags=1` in the same cycle as an overflow-causing capture -> `overflow` remains 1; `clr_flags` the next cycle -> 0.
